// File: rtl/am_pwm_modulator_pkg.sv
// Shared definitions for the AM/PWM modulator: default parameters, counter
// sizing helper, mid-scale duty and the sample-boundary duty source.
package am_pwm_modulator_pkg;

  localparam int unsigned DEF_SAMPLE_BITS        = 8;
  localparam int unsigned DEF_CLKS_PER_STEP      = 1;
  localparam int unsigned DEF_PERIODS_PER_SAMPLE = 63;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [31:0] midscale(input int unsigned w);
    return 32'(1) << (w - 1);
  endfunction

  // Where the duty register is loaded from at a sample boundary.
  typedef enum logic [1:0] {
    BND_NONE  = 2'd0,
    BND_NEXT  = 2'd1,
    BND_FWD   = 2'd2,
    BND_UNDER = 2'd3
  } bnd_src_e;

endpackage

// File: rtl/am_pwm_modulator_pwm_timebase.sv
// PWM timebase: step prescaler, step counter within a PWM period and
// period counter within a sample. Frozen whenever enable_i is low.
module am_pwm_modulator_pwm_timebase
  import am_pwm_modulator_pkg::*;
#(
  parameter int unsigned SAMPLE_BITS        = DEF_SAMPLE_BITS,
  parameter int unsigned CLKS_PER_STEP      = DEF_CLKS_PER_STEP,
  parameter int unsigned PERIODS_PER_SAMPLE = DEF_PERIODS_PER_SAMPLE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  output logic [SAMPLE_BITS-1:0] step_cnt_o,
  output logic                   tc_pwm_step_o,
  output logic                   tc_pwm_symb_o
);

  localparam int unsigned PRE_W = cnt_width(CLKS_PER_STEP);
  localparam int unsigned PER_W = cnt_width(PERIODS_PER_SAMPLE);

  localparam logic [PRE_W-1:0]       PRE_MAX  = PRE_W'(CLKS_PER_STEP - 1);
  localparam logic [SAMPLE_BITS-1:0] STEP_MAX = SAMPLE_BITS'((2 ** SAMPLE_BITS) - 2);
  localparam logic [PER_W-1:0]       PER_MAX  = PER_W'(PERIODS_PER_SAMPLE - 1);

  logic [PRE_W-1:0]       presc_q, presc_d;
  logic [SAMPLE_BITS-1:0] step_q, step_d;
  logic [PER_W-1:0]       per_q, per_d;

  logic step_tick;
  logic step_wrap;

  assign step_tick = enable_i & (presc_q == PRE_MAX);
  assign step_wrap = step_tick & (step_q == STEP_MAX);

  always_comb begin
    presc_d = presc_q;
    step_d  = step_q;
    per_d   = per_q;
    if (enable_i) begin
      presc_d = step_tick ? '0 : presc_q + 1'b1;
    end
    if (step_tick) begin
      step_d = step_wrap ? '0 : step_q + 1'b1;
    end
    if (step_wrap) begin
      per_d = (per_q == PER_MAX) ? '0 : per_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      step_q  <= '0;
      per_q   <= '0;
    end else begin
      presc_q <= presc_d;
      step_q  <= step_d;
      per_q   <= per_d;
    end
  end

  assign step_cnt_o    = step_q;
  assign tc_pwm_step_o = step_wrap;
  assign tc_pwm_symb_o = step_wrap & (per_q == PER_MAX);

endmodule

// File: rtl/am_pwm_modulator.sv
// AM/PWM modulation stage: one-deep sample prefetch from the FIFO, duty hold
// for a fixed number of PWM periods, mid-scale fallback on underrun.
module am_pwm_modulator
  import am_pwm_modulator_pkg::*;
#(
  parameter int unsigned SAMPLE_BITS        = DEF_SAMPLE_BITS,
  parameter int unsigned CLKS_PER_STEP      = DEF_CLKS_PER_STEP,
  parameter int unsigned PERIODS_PER_SAMPLE = DEF_PERIODS_PER_SAMPLE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [SAMPLE_BITS-1:0] sample,
  input  logic                   empty,
  output logic                   read,
  output logic                   pwm,
  output logic                   underrun,
  output logic                   tc_pwm_step,
  output logic                   tc_pwm_symb
);

  localparam logic [SAMPLE_BITS-1:0] MIDSCALE = SAMPLE_BITS'(midscale(SAMPLE_BITS));

  logic [SAMPLE_BITS-1:0] step_cnt;
  logic                   tc_step;
  logic                   tc_symb;

  logic [SAMPLE_BITS-1:0] duty_q, duty_d;
  logic [SAMPLE_BITS-1:0] next_duty_q, next_duty_d;
  logic                   next_valid_q, next_valid_d;
  logic                   rd_pending_q, rd_pending_d;
  logic                   pwm_q, pwm_d;

  logic     read_req;
  logic     capture;
  bnd_src_e bnd_src;

  am_pwm_modulator_pwm_timebase #(
    .SAMPLE_BITS        (SAMPLE_BITS),
    .CLKS_PER_STEP      (CLKS_PER_STEP),
    .PERIODS_PER_SAMPLE (PERIODS_PER_SAMPLE)
  ) u_timebase (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable),
    .step_cnt_o    (step_cnt),
    .tc_pwm_step_o (tc_step),
    .tc_pwm_symb_o (tc_symb)
  );

  // rst gates the strobe so the FIFO sees no read while both are held in reset.
  assign read_req = enable & ~rst & ~next_valid_q & ~rd_pending_q & ~empty;
  assign capture  = rd_pending_q;

  always_comb begin
    bnd_src = BND_NONE;
    if (tc_symb) begin
      if (next_valid_q) begin
        bnd_src = BND_NEXT;
      end else if (capture) begin
        bnd_src = BND_FWD;
      end else begin
        bnd_src = BND_UNDER;
      end
    end
  end

  always_comb begin
    duty_d       = duty_q;
    next_duty_d  = next_duty_q;
    next_valid_d = next_valid_q;
    rd_pending_d = read_req;
    pwm_d        = enable & (step_cnt < duty_q);

    // Capture is independent of enable so an in-flight read never loses data.
    if (capture) begin
      next_duty_d  = sample;
      next_valid_d = 1'b1;
    end

    // A capture landing on the boundary goes straight to duty, bypassing the prefetch slot.
    unique case (bnd_src)
      BND_NEXT: begin
        duty_d       = next_duty_q;
        next_valid_d = 1'b0;
      end
      BND_FWD: begin
        duty_d       = sample;
        next_valid_d = 1'b0;
      end
      BND_UNDER: begin
        duty_d = MIDSCALE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q       <= MIDSCALE;
      next_duty_q  <= '0;
      next_valid_q <= 1'b0;
      rd_pending_q <= 1'b0;
      pwm_q        <= 1'b0;
    end else begin
      duty_q       <= duty_d;
      next_duty_q  <= next_duty_d;
      next_valid_q <= next_valid_d;
      rd_pending_q <= rd_pending_d;
      pwm_q        <= pwm_d;
    end
  end

  assign read        = read_req;
  assign pwm         = pwm_q;
  assign underrun    = (bnd_src == BND_UNDER);
  assign tc_pwm_step = tc_step;
  assign tc_pwm_symb = tc_symb;

endmodule

// File: tb/tb_am_pwm_modulator.sv
// Directed bench for am_pwm_modulator with W=8, 1 clk/step, 2 periods/sample
// (255 clk per PWM period, 510 clk per sample), FIFO modelled by a queue.
module tb_am_pwm_modulator;

  localparam int unsigned W   = 8;
  localparam int unsigned CPS = 1;
  localparam int unsigned PPS = 2;
  localparam int          NLOG = 4096;
  localparam int S_PWM = 0, S_RD = 1, S_UND = 2, S_STP = 3, S_SYM = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b1;
  logic [W-1:0] sample = '0;
  logic         empty = 1'b1;
  logic         read, pwm, underrun, tc_pwm_step, tc_pwm_symb;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_empty_err = 0;
  bit lg [5][NLOG];
  logic [W-1:0] fifo [$];

  typedef struct {
    logic [W-1:0] smp;
    int           exp_high;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  am_pwm_modulator #(
    .SAMPLE_BITS        (W),
    .CLKS_PER_STEP      (CPS),
    .PERIODS_PER_SAMPLE (PPS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .sample      (sample),
    .empty       (empty),
    .read        (read),
    .pwm         (pwm),
    .underrun    (underrun),
    .tc_pwm_step (tc_pwm_step),
    .tc_pwm_symb (tc_pwm_symb)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int cnt(input int s, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += int'(lg[s][i]);
    return n;
  endfunction

  // One clk: observe outputs mid-cycle, then after the edge act as the FIFO.
  task automatic tick();
    logic rd_now;
    @(negedge clk);
    if (cyc < NLOG) begin
      lg[S_PWM][cyc] = pwm;
      lg[S_RD][cyc]  = read;
      lg[S_UND][cyc] = underrun;
      lg[S_STP][cyc] = tc_pwm_step;
      lg[S_SYM][cyc] = tc_pwm_symb;
    end
    rd_now = read;
    @(posedge clk);
    #1;
    if (rd_now) begin
      if (fifo.size() > 0) sample = fifo.pop_front();
      else rd_empty_err++;
    end
    empty = (fifo.size() == 0);
    cyc++;
  endtask

  task automatic push(input logic [W-1:0] v);
    fifo.push_back(v);
    empty = 1'b0;
  endtask

  task automatic start_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    enable = 1'b1;
    fifo.delete();
    sample = '0;
    empty = 1'b1;
  endtask

  task automatic release_reset();
    int bad = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (read | pwm | underrun | tc_pwm_step | tc_pwm_symb) bad++;
      @(posedge clk);
      #1;
    end
    chk("reset_outputs_zero", bad, 0);
    for (int s = 0; s < 5; s++)
      for (int i = 0; i < NLOG; i++) lg[s][i] = 1'b0;
    cyc = 0;
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{smp: 8'h00, exp_high: 0};
    vecs[1] = '{smp: 8'hFF, exp_high: 510};
    vecs[2] = '{smp: 8'h40, exp_high: 128};
    vecs[3] = '{smp: 8'h80, exp_high: 256};
    vecs[4] = '{smp: 8'h01, exp_high: 2};
    vecs[5] = '{smp: 8'hFE, exp_high: 508};

    // Empty FIFO: carrier at mid-scale, underrun at the first boundary.
    start_reset();
    release_reset();
    repeat (1021) tick();
    chk("t1_pwm_high_p0", cnt(S_PWM, 1, 255), 128);
    chk("t1_pwm_high_p1", cnt(S_PWM, 256, 510), 128);
    chk("t1_no_reads", cnt(S_RD, 0, 1020), 0);
    chk("t1_und_before", cnt(S_UND, 0, 508), 0);
    chk("t1_und_at_509", int'(lg[S_UND][509]), 1);
    chk("t1_und_total", cnt(S_UND, 0, 1020), 2);
    chk("t1_step_first", int'(lg[S_STP][254]), 1);
    chk("t1_step_early", cnt(S_STP, 0, 253), 0);
    chk("t1_symb_early", cnt(S_SYM, 0, 508), 0);
    chk("t1_symb_509", int'(lg[S_SYM][509]), 1);

    // One sample per run: duty held for one sample period, then underrun.
    for (int v = 0; v < 6; v++) begin
      start_reset();
      push(vecs[v].smp);
      release_reset();
      repeat (1021) tick();
      chk($sformatf("vec%0d_read_c0", v), int'(lg[S_RD][0]), 1);
      chk($sformatf("vec%0d_reads", v), cnt(S_RD, 0, 1020), 1);
      chk($sformatf("vec%0d_pwm_high", v), cnt(S_PWM, 511, 1020), vecs[v].exp_high);
      chk($sformatf("vec%0d_und", v), cnt(S_UND, 0, 1020), 1);
      chk($sformatf("vec%0d_tc_step", v), cnt(S_STP, 0, 1020), 4);
      chk($sformatf("vec%0d_tc_symb", v), cnt(S_SYM, 0, 1020), 2);
    end

    // Three queued samples, then the FIFO runs dry.
    start_reset();
    push(8'h10);
    push(8'h20);
    push(8'h30);
    release_reset();
    repeat (2300) tick();
    chk("t4_pwm_10", cnt(S_PWM, 511, 1020), 32);
    chk("t4_pwm_20", cnt(S_PWM, 1021, 1530), 64);
    chk("t4_pwm_30", cnt(S_PWM, 1531, 2040), 96);
    chk("t4_pwm_mid", cnt(S_PWM, 2041, 2295), 128);
    chk("t4_reads", cnt(S_RD, 0, 2299), 3);
    chk("t4_read_510", int'(lg[S_RD][510]), 1);
    chk("t4_read_1020", int'(lg[S_RD][1020]), 1);
    chk("t4_und_none", cnt(S_UND, 0, 2038), 0);
    chk("t4_und_2039", int'(lg[S_UND][2039]), 1);
    chk("t4_und_after", cnt(S_UND, 2040, 2299), 0);

    // Disable for 100 clk at step 50, with a sample arriving while disabled.
    start_reset();
    release_reset();
    repeat (50) tick();
    enable = 1'b0;
    repeat (10) tick();
    push(8'h55);
    repeat (90) tick();
    enable = 1'b1;
    repeat (470) tick();
    chk("t5_pwm_before", cnt(S_PWM, 1, 50), 50);
    chk("t5_pwm_disabled", cnt(S_PWM, 51, 150), 0);
    chk("t5_pwm_resume", cnt(S_PWM, 151, 355), 78);
    chk("t5_no_read_disabled", cnt(S_RD, 0, 149), 0);
    chk("t5_read_resume", int'(lg[S_RD][150]), 1);
    chk("t5_step_frozen", cnt(S_STP, 0, 353), 0);
    chk("t5_step_354", int'(lg[S_STP][354]), 1);
    chk("t5_symb_609", int'(lg[S_SYM][609]), 1);
    chk("t5_no_und", cnt(S_UND, 0, 619), 0);

    // Capture lands exactly on the sample boundary.
    start_reset();
    release_reset();
    repeat (508) tick();
    push(8'h20);
    repeat (513) tick();
    chk("t6_read_508", int'(lg[S_RD][508]), 1);
    chk("t6_reads", cnt(S_RD, 0, 1020), 1);
    chk("t6_no_und", cnt(S_UND, 0, 1018), 0);
    chk("t6_und_1019", int'(lg[S_UND][1019]), 1);
    chk("t6_pwm_fwd", cnt(S_PWM, 511, 765), 32);

    chk("read_while_empty", rd_empty_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
